// File: rtl/riscv_pcgen.sv
// Fetch program-counter generator: trap > mret > branch > sequential,
// with redirects captured while stalled and replayed on release.
module riscv_pcgen #(
    parameter int unsigned XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = 64'h8000_0000,
    parameter bit          C_EXT        = 1'b1
) (
    input  logic            i_riscv_pc_clk,
    input  logic            i_riscv_pc_rst,
    input  logic            i_riscv_pcgen_stall,
    input  logic            i_riscv_pcgen_compressed,
    input  logic            i_riscv_pcgen_br_taken,
    input  logic [XLEN-1:0] i_riscv_pcgen_br_target,
    input  logic            i_riscv_pcgen_trap,
    input  logic            i_riscv_pcgen_interrupt,
    input  logic [5:0]      i_riscv_pcgen_cause,
    input  logic [XLEN-1:0] i_riscv_pcgen_mtvec,
    input  logic            i_riscv_pcgen_mret,
    input  logic [XLEN-1:0] i_riscv_pcgen_mepc,
    output logic [XLEN-1:0] o_riscv_pcgen_pc,
    output logic [XLEN-1:0] o_riscv_pcgen_pcplus,
    output logic            o_riscv_pcgen_valid,
    output logic            o_riscv_pcgen_redirect,
    output logic            o_riscv_pcgen_misaligned
);

    localparam logic [XLEN-1:0] RST_PC = RESET_VECTOR[XLEN-1:0];

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_PEND
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_pend;
    logic [XLEN-1:0] w_pend_nxt;
    logic            r_pend_trap;
    logic            w_pend_trap_nxt;
    logic            r_redirect;
    logic            w_redirect_nxt;
    logic            r_misaligned;
    logic            w_misaligned_nxt;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_pcplus;
    logic [XLEN-1:0] w_tvec_base;
    logic [XLEN-1:0] w_cause_off;
    logic            w_vectored;
    logic [XLEN-1:0] w_trap_tgt;
    logic [XLEN-1:0] w_mret_mask;
    logic [XLEN-1:0] w_mret_tgt;
    logic [XLEN-1:0] w_br_tgt;
    logic            w_br_mis;
    logic            w_br_live;
    logic            w_live;
    logic            w_sel_trap;
    logic            w_sel_mret;
    logic            w_sel_br;
    logic [XLEN-1:0] w_live_tgt;

    assign w_step   = (C_EXT && i_riscv_pcgen_compressed) ? XLEN'(2) : XLEN'(4);
    assign w_pcplus = r_pc + w_step;

    // Vectored mode only offsets interrupts; exceptions use the base
    assign w_tvec_base = {i_riscv_pcgen_mtvec[XLEN-1:2], 2'b00};
    assign w_cause_off = XLEN'({i_riscv_pcgen_cause, 2'b00});
    assign w_vectored  = (i_riscv_pcgen_mtvec[1:0] == 2'b01) &&
                         i_riscv_pcgen_interrupt;
    assign w_trap_tgt  = w_vectored ? (w_tvec_base + w_cause_off)
                                    : w_tvec_base;

    assign w_mret_mask = C_EXT ? ~XLEN'(1) : ~XLEN'(3);
    assign w_mret_tgt  = i_riscv_pcgen_mepc & w_mret_mask;
    assign w_br_tgt    = {i_riscv_pcgen_br_target[XLEN-1:1], 1'b0};

    assign w_br_mis  = !C_EXT && i_riscv_pcgen_br_taken &&
                       i_riscv_pcgen_br_target[1];
    assign w_br_live = i_riscv_pcgen_br_taken && !w_br_mis;

    assign w_sel_trap = i_riscv_pcgen_trap;
    assign w_sel_mret = i_riscv_pcgen_mret && !i_riscv_pcgen_trap;
    assign w_sel_br   = w_br_live && !i_riscv_pcgen_trap &&
                        !i_riscv_pcgen_mret;
    assign w_live     = w_sel_trap || w_sel_mret || w_sel_br;

    always_comb begin
        w_live_tgt = w_pcplus;
        unique case (1'b1)
            w_sel_trap: w_live_tgt = w_trap_tgt;
            w_sel_mret: w_live_tgt = w_mret_tgt;
            w_sel_br:   w_live_tgt = w_br_tgt;
            default:    w_live_tgt = w_pcplus;
        endcase
    end

    always_ff @(posedge i_riscv_pc_clk or posedge i_riscv_pc_rst) begin
        if (i_riscv_pc_rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RST_PC;
            r_pend       <= '0;
            r_pend_trap  <= 1'b0;
            r_redirect   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_trap  <= w_pend_trap_nxt;
            r_redirect   <= w_redirect_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_nxt       = r_pend;
        w_pend_trap_nxt  = r_pend_trap;
        w_redirect_nxt   = 1'b0;
        w_misaligned_nxt = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_misaligned_nxt = w_br_mis;
                if (!i_riscv_pcgen_stall) begin
                    w_pc_nxt       = w_live_tgt;
                    w_redirect_nxt = w_live;
                end else if (w_live) begin
                    w_pend_nxt      = w_live_tgt;
                    w_pend_trap_nxt = w_sel_trap;
                    w_state_nxt     = S_PEND;
                end
            end
            S_PEND: begin
                w_misaligned_nxt = w_br_mis;
                if (i_riscv_pcgen_stall) begin
                    // A pending trap can only be replaced by a newer trap
                    if (w_sel_trap) begin
                        w_pend_nxt      = w_trap_tgt;
                        w_pend_trap_nxt = 1'b1;
                    end else if (w_sel_mret && !r_pend_trap) begin
                        w_pend_nxt = w_mret_tgt;
                    end
                end else begin
                    w_pc_nxt        = w_live ? w_live_tgt : r_pend;
                    w_redirect_nxt  = 1'b1;
                    w_pend_nxt      = '0;
                    w_pend_trap_nxt = 1'b0;
                    w_state_nxt     = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign o_riscv_pcgen_pc         = r_pc;
    assign o_riscv_pcgen_pcplus     = w_pcplus;
    assign o_riscv_pcgen_valid      = (r_state != S_BOOT);
    assign o_riscv_pcgen_redirect   = r_redirect;
    assign o_riscv_pcgen_misaligned = r_misaligned;

endmodule

// File: doc/riscv_pcgen.md
# riscv_pcgen

Parametrised program-counter generator for the RV64IMC fetch stage, replacing the plain stall-able PC register. It holds the fetch PC and computes the next PC from a fixed-priority set of sources: trap, mret, taken branch/jump, sequential +2/+4. Redirects that arrive while fetch is stalled are latched and applied when the stall releases. A one-cycle boot state follows reset. A registered redirect pulse drives pipeline flush.

## Interface
- XLEN, 64, PC width.
- RESET_VECTOR, 64'h8000_0000, PC value loaded on reset (truncated to XLEN).
- C_EXT, 1, compressed support; 0 = 4-byte granularity only.

- i_riscv_pc_clk  in  1  clock, rising edge.
- i_riscv_pc_rst  in  1  reset, asynchronous, active-high.
- i_riscv_pcgen_stall  in  1  hold PC (fetch/decode stall).
- i_riscv_pcgen_compressed  in  1  instruction at current PC is 16-bit.
- i_riscv_pcgen_br_taken  in  1  branch/jump resolved taken (EX).
- i_riscv_pcgen_br_target  in  XLEN  branch/jump target.
- i_riscv_pcgen_trap  in  1  take trap (CSR unit).
- i_riscv_pcgen_interrupt  in  1  trap is an interrupt.
- i_riscv_pcgen_cause  in  6  trap cause code.
- i_riscv_pcgen_mtvec  in  XLEN  mtvec CSR value.
- i_riscv_pcgen_mret  in  1  mret retiring.
- i_riscv_pcgen_mepc  in  XLEN  mepc CSR value.
- o_riscv_pcgen_pc  out  XLEN  current fetch PC.
- o_riscv_pcgen_pcplus  out  XLEN  PC + 2 or + 4 (combinational).
- o_riscv_pcgen_valid  out  1  PC valid for fetch.
- o_riscv_pcgen_redirect  out  1  registered pulse: PC was loaded from a redirect source this edge.
- o_riscv_pcgen_misaligned  out  1  registered pulse: branch target misaligned, redirect suppressed.

## Operation
- Reset values: pc = RESET_VECTOR, valid = 0, redirect = 0, misaligned = 0, pending = 0, state = BOOT.
- States: BOOT, RUN, PEND.
  - BOOT: valid = 0, PC holds, all inputs ignored. Moves to RUN on the next edge unconditionally.
  - RUN: valid = 1. If not stalled, PC loads the highest-priority live source. If stalled and any redirect is live, the target is captured in the pending register; go to PEND. PC holds.
  - PEND: valid = 1, PC holds while stalled.
    - A live trap overwrites the pending target. A live mret overwrites pending unless pending is a trap. A live branch overwrites nothing.
    - When stall is low: PC loads the live redirect if one exists, else the pending target. Pending clears. Go to RUN.
- Priority of live sources: trap > mret > branch > sequential.
- Targets:
  - Sequential: pc + 2 when compressed = 1 and C_EXT = 1; otherwise pc + 4.
  - Trap target:
    - mtvec[1:0] = 01 and interrupt = 1: {mtvec[XLEN-1:2],2'b00} + (cause << 2).
    - Otherwise: {mtvec[XLEN-1:2],2'b00}.
  - mret: mepc with bit 0 cleared; bit 1 also cleared when C_EXT = 0.
  - Branch: br_target with bit 0 cleared.
- Misaligned branch: when C_EXT = 0 and br_target[1] = 1, the branch redirect is suppressed. The next-state choice proceeds as if br_taken = 0. misaligned pulses the next cycle, even if stalled. The CSR unit raises the trap.
- Arithmetic: all additions modulo 2^XLEN; wrap-around is silent.
- redirect = 1 for exactly one cycle after any edge on which PC loaded a trap/mret/branch/pending target.

## Timing
- Redirect latency is one edge: an input sampled at edge N gives the new PC after edge N, and redirect = 1 during cycle N+1.
- Stall applies in the same cycle: if stall = 1 at edge N, PC after N equals PC before N.
- pcplus is combinational from pc, compressed and C_EXT, with zero latency.
- Simultaneous trap + mret + branch: the trap wins; the others are dropped, not queued.
- Reset asserted mid-operation immediately forces reset values and drops pending. The first PC change after reset deassertion happens no earlier than the second rising edge.

## Test plan
- Reset then free-run with compressed = 0: valid = 0 for 1 cycle, then pc = 8000_0000, 8000_0004, 8000_0008. Pulse compressed = 1 once: the next step is +2.
- Taken branch to 8000_1000 with no stall: pc = 8000_1000 the next cycle, redirect = 1 for one cycle. Trap + branch in the same cycle with mtvec = 8000_0200: pc = 8000_0200.
- Vectored interrupt, mtvec = 8000_0301, cause = 7, interrupt = 1: pc = 8000_031C. Same inputs with interrupt = 0: pc = 8000_0300.
- Stall for 3 cycles:
  - Branch to 8000_2000 in cycle 1 and mret with mepc = 8000_3000 in cycle 2. On release, pc = 8000_3000 and redirect pulses once.
  - Repeat with trap in cycle 1 then mret: pc = trap target.
- C_EXT = 0, branch target 8000_0042: misaligned pulses, PC continues sequentially, redirect = 0.
- Wrap and reset: pc = FFFF_FFFF_FFFF_FFFC steps to 0. Assert reset during PEND: pc = 8000_0000 asynchronously and the pending target is never applied.
